// File: rtl/led_blinker_pkg.sv
// Shared types and helpers for the multi-channel LED blinker.
//   MODE_*      : channel mode encodings (2 bits)
//   mode_t      : channel mode type
//   RATE_W      : width of the rate-select field
//   ch_width()  : channel-select width for a given channel count
//   tap_sel()   : prescaler tap index for a rate select, clamped at bit 0
package led_blinker_pkg;

    localparam int unsigned RATE_W = 4;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'd0;
    localparam mode_t MODE_ON      = 2'd1;
    localparam mode_t MODE_BLINK   = 2'd2;
    localparam mode_t MODE_BREATHE = 2'd3;

    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Larger rate selects pick lower (faster) prescaler bits; past the
    // bottom of the counter the tap sticks at bit 0.
    function automatic int unsigned tap_sel(input logic [RATE_W-1:0] rate,
                                            input int unsigned cbits);
        int unsigned r;
        r = {{(32 - RATE_W){1'b0}}, rate};
        return (r > cbits - 1) ? 0 : cbits - 1 - r;
    endfunction

endpackage

// File: rtl/led_blinker_if.sv
// Configuration write port of the LED blinker.
//   i_wr_en   : single-cycle write strobe
//   i_wr_ch   : target channel (ch_width(NCH) bits)
//   i_wr_mode : OFF / ON / BLINK / BREATHE
//   i_wr_rate : rate select
// master drives the port, slave (the blinker) receives it.
interface led_blinker_if
    import led_blinker_pkg::*;
#(
    parameter int unsigned NCH = 3
);
    localparam int unsigned CHW = ch_width(NCH);

    logic              i_wr_en;
    logic [CHW-1:0]    i_wr_ch;
    mode_t             i_wr_mode;
    logic [RATE_W-1:0] i_wr_rate;

    modport master (output i_wr_en, output i_wr_ch, output i_wr_mode, output i_wr_rate);
    modport slave  (input  i_wr_en, input  i_wr_ch, input  i_wr_mode, input  i_wr_rate);

endinterface

// File: rtl/led_blinker_ch.sv
// One LED channel: mode/rate registers, optional breathe duty/direction
// state, and the registered LED output.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_we         : write strobe already decoded for this channel
//   i_mode       : mode to load on a write
//   i_rate       : rate select to load on a write
//   i_cnt        : shared prescaler value
//   o_led        : registered LED drive
// Macro LED_BLINKER_BREATHE_EN builds the breathe PWM; without it mode 3
// behaves as BLINK.
module led_blinker_ch
    import led_blinker_pkg::*;
#(
    parameter int unsigned CBITS    = 26,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  mode_t             i_mode,
    input  logic [RATE_W-1:0] i_rate,
    input  logic [CBITS-1:0]  i_cnt,
    output logic              o_led
);

    if (PWM_BITS > CBITS || CBITS < 2) begin : g_bad_params
        $error("led_blinker_ch: need CBITS >= PWM_BITS and CBITS >= 2");
    end

    mode_t             mode_q;
    logic [RATE_W-1:0] rate_q;
    logic [CBITS-1:0]  tap_mask;
    logic [CBITS-1:0]  tap_onehot;
    logic              tap_bit;
    logic              step;
    logic              led_d;
    logic              led_q;

    // tap_mask covers cnt[b:0]; a step fires when all of those bits are one.
    always_comb begin
        int unsigned b;
        b          = tap_sel(rate_q, CBITS);
        tap_mask   = '0;
        tap_onehot = '0;
        for (int unsigned i = 0; i < CBITS; i++) begin
            tap_mask[i]   = (i <= b);
            tap_onehot[i] = (i == b);
        end
        tap_bit = |(i_cnt & tap_onehot);
        step    = &(i_cnt | ~tap_mask);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q <= MODE_OFF;
            rate_q <= '0;
        end else if (i_we) begin
            mode_q <= i_mode;
            rate_q <= i_rate;
        end
    end

`ifdef LED_BLINKER_BREATHE_EN
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                up_q, up_d;
    logic                pwm_on;

    assign pwm_on = i_cnt[PWM_BITS-1:0] < duty_q;

    // Direction flips at an extreme and the same step moves away from it,
    // so the duty never dwells at 0 or max. A write beats a step.
    always_comb begin
        duty_d = duty_q;
        up_d   = up_q;
        if (i_we) begin
            duty_d = '0;
            up_d   = 1'b1;
        end else if (mode_q == MODE_BREATHE && step) begin
            if (up_q && (&duty_q)) begin
                up_d = 1'b0;
            end else if (!up_q && duty_q == '0) begin
                up_d = 1'b1;
            end
            duty_d = up_d ? duty_q + PWM_BITS'(1) : duty_q - PWM_BITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            duty_q <= '0;
            up_q   <= 1'b1;
        end else begin
            duty_q <= duty_d;
            up_q   <= up_d;
        end
    end
`else
    logic pwm_on;
    logic unused_step;
    assign pwm_on      = tap_bit;
    assign unused_step = step;
`endif

    always_comb begin
        led_d = 1'b0;
        case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = tap_bit;
            default:    led_d = pwm_on;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: rtl/led_blinker.sv
// Multi-channel LED blinker: one free-running prescaler shared by NCH
// independently configured channels (OFF / ON / BLINK / BREATHE).
//   i_clk, i_rst : clock, synchronous active-high reset
//   cfg          : configuration write port (led_blinker_if.slave)
//   o_led        : registered LED drive, bit n = channel n
//   o_tick       : one-cycle pulse after each prescaler wrap
// Macro LED_BLINKER_BREATHE_EN enables breathe PWM in the channels.
module led_blinker
    import led_blinker_pkg::*;
#(
    parameter int unsigned CBITS    = 26,
    parameter int unsigned NCH      = 3,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    led_blinker_if.slave   cfg,
    output logic [NCH-1:0] o_led,
    output logic           o_tick
);

    localparam int unsigned CHW = ch_width(NCH);

    logic [CBITS-1:0] cnt_q;
    logic             tick_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + CBITS'(1);
            tick_q <= &cnt_q;
        end
    end

    assign o_tick = tick_q;

    // Channel indices at or above NCH match no instance, so such writes
    // fall away silently.
    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic we;
        assign we = cfg.i_wr_en && (cfg.i_wr_ch == CHW'(n));

        led_blinker_ch #(
            .CBITS    (CBITS),
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_we   (we),
            .i_mode (cfg.i_wr_mode),
            .i_rate (cfg.i_wr_rate),
            .i_cnt  (cnt_q),
            .o_led  (o_led[n])
        );
    end

endmodule

// File: tb/tb_led_blinker.sv
`timescale 1ns/1ps
module tb_led_blinker;
    import led_blinker_pkg::*;

    localparam int CBITS    = 4;
    localparam int NCH      = 3;
    localparam int PWM_BITS = 2;
    localparam int CHW      = 2;
    localparam int CMAX     = (1 << CBITS) - 1;
`ifdef LED_BLINKER_BREATHE_EN
    localparam bit BREATHE = 1'b1;
`else
    localparam bit BREATHE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] led;
    logic           tick;

    led_blinker_if #(.NCH(NCH)) cfg_if ();

    led_blinker #(
        .CBITS    (CBITS),
        .NCH      (NCH),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .cfg    (cfg_if),
        .o_led  (led),
        .o_tick (tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt;
    int m_mode [NCH];
    int m_rate [NCH];
    int m_duty [NCH];
    bit m_up   [NCH];

    logic [NCH:0] exp_q [$];

    function automatic int tap(input int r);
        return (r > CBITS - 1) ? 0 : CBITS - 1 - r;
    endfunction

    function automatic logic model_led(input int n);
        int b;
        b = tap(m_rate[n]);
        case (m_mode[n])
            0: return 1'b0;
            1: return 1'b1;
            2: return ((m_cnt >> b) & 1) != 0;
            default: begin
                if (BREATHE) return (m_cnt % (1 << PWM_BITS)) < m_duty[n];
                return ((m_cnt >> b) & 1) != 0;
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: model computes what the DUT must show after the
    // edge, pushes it, then the DUT output is popped and compared.
    task automatic cycle();
        logic [NCH-1:0] e_led;
        logic           e_tick;
        logic [NCH:0]   e;
        int             ch;
        e_led  = '0;
        e_tick = 1'b0;
        if (rst) begin
            m_cnt = 0;
            for (int n = 0; n < NCH; n++) begin
                m_mode[n] = 0; m_rate[n] = 0; m_duty[n] = 0; m_up[n] = 1'b1;
            end
        end else begin
            for (int n = 0; n < NCH; n++) e_led[n] = model_led(n);
            e_tick = (m_cnt == CMAX);
            for (int n = 0; n < NCH; n++) begin
                int mask;
                mask = (2 << tap(m_rate[n])) - 1;
                if (BREATHE && m_mode[n] == 3 && (m_cnt & mask) == mask) begin
                    if (m_up[n] && m_duty[n] == (1 << PWM_BITS) - 1) m_up[n] = 1'b0;
                    else if (!m_up[n] && m_duty[n] == 0) m_up[n] = 1'b1;
                    m_duty[n] = m_up[n] ? m_duty[n] + 1 : m_duty[n] - 1;
                end
            end
            ch = int'(cfg_if.i_wr_ch);
            if (cfg_if.i_wr_en && ch < NCH) begin
                m_mode[ch] = int'(cfg_if.i_wr_mode);
                m_rate[ch] = int'(cfg_if.i_wr_rate);
                m_duty[ch] = 0;
                m_up[ch]   = 1'b1;
            end
            m_cnt = (m_cnt + 1) % (CMAX + 1);
        end
        exp_q.push_back({e_led, e_tick});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("led", {29'd0, led}, {29'd0, e[NCH:1]});
        check("tick", {31'd0, tick}, {31'd0, e[0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input int ch, input int mode, input int rate);
        cfg_if.i_wr_en   = 1'b1;
        cfg_if.i_wr_ch   = CHW'(ch);
        cfg_if.i_wr_mode = mode_t'(mode);
        cfg_if.i_wr_rate = RATE_W'(rate);
        cycle();
        cfg_if.i_wr_en   = 1'b0;
    endtask

    initial begin
        int first;
        int second;
        cfg_if.i_wr_en   = 1'b0;
        cfg_if.i_wr_ch   = '0;
        cfg_if.i_wr_mode = MODE_OFF;
        cfg_if.i_wr_rate = '0;
        rst = 1'b1;
        run(3);
        check("rst_led", {29'd0, led}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        rst = 1'b0;

        // Tick spacing after release, bounded window
        first  = -1;
        second = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (tick === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        check("tick_first", 32'(first), 32'd16);
        check("tick_period", 32'(second - first), 32'd16);

        // ON with one-cycle latency, then BLINK on ch2
        wr(0, 1, 0);
        check("on_before", {31'd0, led[0]}, 32'd0);
        cycle();
        check("on_latency", {31'd0, led[0]}, 32'd1);
        wr(2, 2, 0);
        run(20);

        // ch1 blink at b=1, then clamped b=0
        wr(1, 2, 2);
        run(12);
        wr(1, 2, 9);
        run(8);

        // Breathe on ch0 through several full ramps
        wr(0, 3, 3);
        run(48);

        // Out-of-range channel write is ignored
        wr(3, 1, 0);
        run(4);

        // Write lands on a step event of ch0 (b=0: cnt odd)
        for (int i = 0; i < 4 && (m_cnt % 2 == 0); i++) cycle();
        wr(0, 3, 3);
        run(10);

        // Reset in the middle of breathing
        run(5);
        rst = 1'b1;
        cycle();
        check("rst_mid_led", {29'd0, led}, 32'd0);
        check("rst_mid_tick", {31'd0, tick}, 32'd0);
        rst = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
